pipeline_latectl: RTL and testbench
===================================

# pipeline_latectl

Issue/writeback controller wrapped around the late ALU (shift, mult, mthi/mtlo unit). Accepts late-ALU instructions from decode over a valid/ready handshake and drives the late ALU's op/operand inputs one cycle later. Collects the registered result (or the HI/LO value for mfhi/mflo) and presents it to the register-file write port. Also provides a two-entry scoreboard so decode can stall dependent instructions.

## Interface
Parameters: none.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  block accepts this cycle
- in_op  in  6  2 srl, 3 sra, 4 mult, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
- in_a0, in_a1  in  32  operands (shift value/amount, mult operands, mthi/mtlo source)
- in_rd  in  5  destination GPR (ignored for mult/mthi/mtlo)
- alu_op  out  6  to late ALU op; 0 when idle
- alu_a0, alu_a1  out  32  to late ALU operands
- alu_result  in  32  late ALU result_out
- alu_hi, alu_lo  in  32  late ALU hi/lo
- wb_valid  out  1  write request
- wb_rd  out  5  write address
- wb_data  out  32  write data
- wb_ready  in  1  register file accepts the write
- sb_rd  in  5  decode query register
- sb_hit  out  1  sb_rd has a pending write in E1 or E2 (combinational)
- bad_op  out  1  sticky: an unsupported op was accepted

## Operation
- Two stages:
  - E1: valid, op, a0, a1, rd.
  - E2: valid, rd, is_hilo, hilo_data.
- Writer ops: srl, sra, mfhi, mflo. Non-writers: mult, mthi, mtlo.
- stall = E2.valid & !wb_ready.
- e1_adv = E1.valid & !stall. in_ready = !E1.valid | e1_adv (combinational from wb_ready).
- Accept (in_valid & in_ready): load E1. A supported op with no write has E1.valid=1. An unsupported op is dropped (E1 not loaded) and sets bad_op.
- alu_op = op, only when E1.valid & !stall & !rst & op in {2..6}. Otherwise 0 (ALU holds result_out, hi, lo). alu_a0/a1 = E1 operands at all times.
- mfhi/mflo are never sent to the ALU.
- On e1_adv:
  - If the op is a writer with rd≠0: E2 loads rd. is_hilo=1 for mfhi/mflo, with hilo_data = alu_hi / alu_lo sampled this cycle.
  - Otherwise E2.valid clears, unless E2 is holding.
- E2 clears when wb_valid & wb_ready and no new entry arrives.
- wb_valid = E2.valid. wb_rd = E2.rd. wb_data = E2.is_hilo ? hilo_data : alu_result.
- rd=0 writers execute (shift results are discarded) and never reach E2.
- sb_hit = sb_rd≠0 & ((E1.valid & E1 writer & E1.rd==sb_rd) | (E2.valid & E2.rd==sb_rd)).

## Timing
- Reset values: E1.valid=0, E2.valid=0, bad_op=0, wb_valid=0, alu_op=0, in_ready=1 (after the reset edge), sb_hit=0.
- Reset mid-operation: in-flight instructions are discarded with no write. alu_op is forced 0 during the rst cycle. Late-ALU hi/lo are not restored.
- Shift latency: accept at edge of cycle T. alu_op is valid in T+1. ALU registers at end of T+1. wb_valid with data in T+2.
- mfhi/mflo latency: same, wb in T+2. HI/LO is sampled in T+1, so a mult or mthi/mtlo in E1 during T sets the value read by an mfhi in E1 during T+1. No HI/LO interlock is needed.
- Throughput: one instruction per cycle while wb_ready=1.
- Stall: E1 and E2 hold and alu_op=0. The ALU result_out is unchanged, so wb_data is stable. A non-writer in E1 does not execute until the stall clears.
- Simultaneous: E2 retiring and E1 advancing in the same cycle leaves E2 reloaded with no bubble.

## Test plan
- Reset, then srl: a0=0x80000000, a1=4, rd=3 -> alu_op=2 in T+1; wb_valid, wb_rd=3, wb_data=0x08000000 in T+2.
- sra a0=0x80000000, a1=4, rd=5 -> wb_data=0xF8000000. A back-to-back srl a1=31 rd=6 -> wb_data=1 on the following cycle (no bubble).
- mult a0=0xFFFFFFFF(-1), a1=2, then immediately mfhi rd=7 and mflo rd=8 -> writes 0xFFFFFFFF then 0xFFFFFFFE. No write for the mult.
- wb_ready=0 for 3 cycles with a shift in E2 and srl in E1 -> wb_data constant, alu_op=0, in_ready=0. Both results are written in order after release.
- sb_rd=3 with srl rd=3 in E1 -> sb_hit=1, then in E2 -> sb_hit=1, after write -> 0. rd=0 srl -> sb_hit=0, no wb_valid.
- in_op=9 accepted -> bad_op=1, no alu_op, no wb. rst mid-flight (srl in E1) -> no wb_valid, bad_op=0 afterwards.

Source files
------------

// File: rtl/pipeline_latectl_if.sv
// Decode, late-ALU, writeback and scoreboard signals of the late-ALU issue controller.
// The controller connects through the slave modport; its environment uses master.
interface pipeline_latectl_if;
  // Valid/ready: a transfer happens on a rising clk edge where both valid and
  // ready are high; the offering side holds its payload stable until then.
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_a0;
  logic [31:0] in_a1;
  logic [4:0]  in_rd;

  logic [5:0]  alu_op;
  logic [31:0] alu_a0;
  logic [31:0] alu_a1;
  logic [31:0] alu_result;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  logic [4:0]  sb_rd;
  logic        sb_hit;
  logic        bad_op;

  modport slave (
    input  in_valid, in_op, in_a0, in_a1, in_rd,
    output in_ready,
    output alu_op, alu_a0, alu_a1,
    input  alu_result, alu_hi, alu_lo,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    input  sb_rd,
    output sb_hit, bad_op
  );

  modport master (
    output in_valid, in_op, in_a0, in_a1, in_rd,
    input  in_ready,
    input  alu_op, alu_a0, alu_a1,
    output alu_result, alu_hi, alu_lo,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    output sb_rd,
    input  sb_hit, bad_op
  );
endinterface

// File: rtl/pipeline_latectl.sv
// Two-stage issue/writeback controller for the late ALU (shift, mult, mthi/mtlo,
// mfhi/mflo) with a destination scoreboard for decode stalls.
module pipeline_latectl (
  input  logic               clk,
  input  logic               rst,
  pipeline_latectl_if.slave  bus
);

  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_SRA  = 6'd3;
  localparam logic [5:0] OP_MTLO = 6'd6;
  localparam logic [5:0] OP_MFHI = 6'd7;
  localparam logic [5:0] OP_MFLO = 6'd8;

  function automatic logic op_supported(input logic [5:0] op);
    return (op >= OP_SRL) && (op <= OP_MFLO);
  endfunction

  function automatic logic op_to_alu(input logic [5:0] op);
    return (op >= OP_SRL) && (op <= OP_MTLO);
  endfunction

  function automatic logic op_writes(input logic [5:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  // E1 stage
  logic        e1_valid_q, e1_valid_d;
  logic [5:0]  e1_op_q,    e1_op_d;
  logic [31:0] e1_a0_q,    e1_a0_d;
  logic [31:0] e1_a1_q,    e1_a1_d;
  logic [4:0]  e1_rd_q,    e1_rd_d;

  // E2 stage
  logic        e2_valid_q,   e2_valid_d;
  logic [4:0]  e2_rd_q,      e2_rd_d;
  logic        e2_is_hilo_q, e2_is_hilo_d;
  logic [31:0] e2_hilo_q,    e2_hilo_d;

  logic        bad_op_q, bad_op_d;

  logic stall;
  logic e1_adv;
  logic in_ready;
  logic accept;
  logic e2_load;

  always_comb begin
    stall    = e2_valid_q & ~bus.wb_ready;
    e1_adv   = e1_valid_q & ~stall;
    in_ready = ~e1_valid_q | e1_adv;
    accept   = bus.in_valid & in_ready;
    // rd=0 writers still execute in the ALU but never occupy the write port.
    e2_load  = e1_adv & op_writes(e1_op_q) & (e1_rd_q != 5'd0);
  end

  always_comb begin
    e1_valid_d = e1_valid_q;
    e1_op_d    = e1_op_q;
    e1_a0_d    = e1_a0_q;
    e1_a1_d    = e1_a1_q;
    e1_rd_d    = e1_rd_q;
    if (accept && op_supported(bus.in_op)) begin
      e1_valid_d = 1'b1;
      e1_op_d    = bus.in_op;
      e1_a0_d    = bus.in_a0;
      e1_a1_d    = bus.in_a1;
      e1_rd_d    = bus.in_rd;
    end else if (e1_adv) begin
      e1_valid_d = 1'b0;
    end
  end

  // HI/LO is sampled while the mfhi/mflo sits in E1, so a mult/mthi/mtlo one
  // slot ahead has already updated it; no HI/LO interlock is required.
  always_comb begin
    e2_valid_d   = e2_valid_q;
    e2_rd_d      = e2_rd_q;
    e2_is_hilo_d = e2_is_hilo_q;
    e2_hilo_d    = e2_hilo_q;
    if (e2_load) begin
      e2_valid_d   = 1'b1;
      e2_rd_d      = e1_rd_q;
      e2_is_hilo_d = (e1_op_q == OP_MFHI) || (e1_op_q == OP_MFLO);
      e2_hilo_d    = (e1_op_q == OP_MFHI) ? bus.alu_hi : bus.alu_lo;
    end else if (!stall) begin
      e2_valid_d = 1'b0;
    end
  end

  always_comb begin
    bad_op_d = bad_op_q | (accept & ~op_supported(bus.in_op));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid_q <= 1'b0;
      e2_valid_q <= 1'b0;
      bad_op_q   <= 1'b0;
    end else begin
      e1_valid_q <= e1_valid_d;
      e2_valid_q <= e2_valid_d;
      bad_op_q   <= bad_op_d;
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    e1_op_q      <= e1_op_d;
    e1_a0_q      <= e1_a0_d;
    e1_a1_q      <= e1_a1_d;
    e1_rd_q      <= e1_rd_d;
    e2_rd_q      <= e2_rd_d;
    e2_is_hilo_q <= e2_is_hilo_d;
    e2_hilo_q    <= e2_hilo_d;
  end

  // While stalled alu_op stays 0, so result_out holds the value E2 is waiting to write.
  always_comb begin
    bus.in_ready = in_ready;
    bus.alu_op   = (e1_valid_q & ~stall & ~rst & op_to_alu(e1_op_q)) ? e1_op_q : 6'd0;
    bus.alu_a0   = e1_a0_q;
    bus.alu_a1   = e1_a1_q;
    bus.wb_valid = e2_valid_q;
    bus.wb_rd    = e2_rd_q;
    bus.wb_data  = e2_is_hilo_q ? e2_hilo_q : bus.alu_result;
    bus.bad_op   = bad_op_q;
    bus.sb_hit   = (bus.sb_rd != 5'd0) &
                   ((e1_valid_q & op_writes(e1_op_q) & (e1_rd_q == bus.sb_rd)) |
                    (e2_valid_q & (e2_rd_q == bus.sb_rd)));
  end

endmodule

// File: tb/tb_pipeline_latectl.sv
// Directed bench for pipeline_latectl with a behavioural late-ALU beside it.
module tb_pipeline_latectl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_latectl_if bus ();

  pipeline_latectl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Late ALU: registered result_out plus HI/LO, all holding when op is 0.
  logic [31:0] alu_result_q = 32'd0;
  logic [31:0] alu_hi_q     = 32'd0;
  logic [31:0] alu_lo_q     = 32'd0;
  logic [63:0] prod;

  always_comb begin
    prod = {{32{bus.alu_a0[31]}}, bus.alu_a0} * {{32{bus.alu_a1[31]}}, bus.alu_a1};
  end

  always @(posedge clk) begin
    case (bus.alu_op)
      6'd2: alu_result_q <= bus.alu_a0 >> bus.alu_a1[4:0];
      6'd3: alu_result_q <= $unsigned($signed(bus.alu_a0) >>> bus.alu_a1[4:0]);
      6'd4: begin
        alu_hi_q <= prod[63:32];
        alu_lo_q <= prod[31:0];
      end
      6'd5: alu_hi_q <= bus.alu_a0;
      6'd6: alu_lo_q <= bus.alu_a0;
      default: ;
    endcase
  end

  assign bus.alu_result = alu_result_q;
  assign bus.alu_hi     = alu_hi_q;
  assign bus.alu_lo     = alu_lo_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a0    = a0;
    bus.in_a1    = a1;
    bus.in_rd    = rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_op    = 6'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.in_a0    = 32'd0;
    bus.in_a1    = 32'd0;
    bus.in_rd    = 5'd0;
    bus.wb_ready = 1'b1;
    bus.sb_rd    = 5'd3;

    // reset
    step();
    sample();
    check("rst_alu_op", {26'd0, bus.alu_op}, 32'd0);
    step();
    rst = 1'b0;
    sample();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_bad_op",   {31'd0, bus.bad_op},   32'd0);
    check("rst_sb_hit",   {31'd0, bus.sb_hit},   32'd0);
    check("rst_alu_op2",  {26'd0, bus.alu_op},   32'd0);

    // srl 0x80000000 >> 4 to r3, scoreboard tracks r3 through both stages
    step();
    drive(6'd2, 32'h8000_0000, 32'd4, 5'd3);
    sample();
    check("srl_accept_sb", {31'd0, bus.sb_hit}, 32'd0);
    step();
    idle();
    sample();
    check("srl_alu_op", {26'd0, bus.alu_op}, 32'd2);
    check("srl_alu_a0", bus.alu_a0, 32'h8000_0000);
    check("srl_alu_a1", bus.alu_a1, 32'd4);
    check("srl_e1_sb",  {31'd0, bus.sb_hit}, 32'd1);
    check("srl_e1_wbv", {31'd0, bus.wb_valid}, 32'd0);
    step();
    sample();
    check("srl_wbv",   {31'd0, bus.wb_valid}, 32'd1);
    check("srl_wbrd",  {27'd0, bus.wb_rd}, 32'd3);
    check("srl_wbd",   bus.wb_data, 32'h0800_0000);
    check("srl_e2_sb", {31'd0, bus.sb_hit}, 32'd1);
    step();
    sample();
    check("srl_done_wbv", {31'd0, bus.wb_valid}, 32'd0);
    check("srl_done_sb",  {31'd0, bus.sb_hit}, 32'd0);

    // sra then back-to-back srl
    drive(6'd3, 32'h8000_0000, 32'd4, 5'd5);
    step();
    drive(6'd2, 32'h8000_0000, 32'd31, 5'd6);
    sample();
    check("sra_alu_op", {26'd0, bus.alu_op}, 32'd3);
    step();
    idle();
    sample();
    check("b2b_alu_op", {26'd0, bus.alu_op}, 32'd2);
    check("sra_wbv",    {31'd0, bus.wb_valid}, 32'd1);
    check("sra_wbrd",   {27'd0, bus.wb_rd}, 32'd5);
    check("sra_wbd",    bus.wb_data, 32'hF800_0000);
    step();
    sample();
    check("b2b_wbv",  {31'd0, bus.wb_valid}, 32'd1);
    check("b2b_wbrd", {27'd0, bus.wb_rd}, 32'd6);
    check("b2b_wbd",  bus.wb_data, 32'd1);
    step();
    sample();
    check("b2b_done", {31'd0, bus.wb_valid}, 32'd0);

    // mult -1*2, then mfhi r7, mflo r8
    drive(6'd4, 32'hFFFF_FFFF, 32'd2, 5'd0);
    step();
    drive(6'd7, 32'd0, 32'd0, 5'd7);
    sample();
    check("mult_alu_op", {26'd0, bus.alu_op}, 32'd4);
    step();
    drive(6'd8, 32'd0, 32'd0, 5'd8);
    sample();
    check("mfhi_alu_op", {26'd0, bus.alu_op}, 32'd0);
    check("mult_no_wb",  {31'd0, bus.wb_valid}, 32'd0);
    step();
    idle();
    sample();
    check("mfhi_wbv",  {31'd0, bus.wb_valid}, 32'd1);
    check("mfhi_wbrd", {27'd0, bus.wb_rd}, 32'd7);
    check("mfhi_wbd",  bus.wb_data, 32'hFFFF_FFFF);
    step();
    sample();
    check("mflo_wbv",  {31'd0, bus.wb_valid}, 32'd1);
    check("mflo_wbrd", {27'd0, bus.wb_rd}, 32'd8);
    check("mflo_wbd",  bus.wb_data, 32'hFFFF_FFFE);
    step();
    sample();
    check("mflo_done", {31'd0, bus.wb_valid}, 32'd0);

    // stall: srl r9 in E2, srl r10 in E1, write port busy 3 cycles
    drive(6'd2, 32'h0000_00F0, 32'd4, 5'd9);
    step();
    drive(6'd2, 32'h0000_1000, 32'd4, 5'd10);
    step();
    idle();
    bus.wb_ready = 1'b0;
    bus.sb_rd    = 5'd10;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stall_wbd",   bus.wb_data, 32'h0000_000F);
      check("stall_wbrd",  {27'd0, bus.wb_rd}, 32'd9);
      check("stall_aluop", {26'd0, bus.alu_op}, 32'd0);
      check("stall_rdy",   {31'd0, bus.in_ready}, 32'd0);
      check("stall_sb",    {31'd0, bus.sb_hit}, 32'd1);
      step();
    end
    bus.wb_ready = 1'b1;
    sample();
    check("rel_wbv",   {31'd0, bus.wb_valid}, 32'd1);
    check("rel_wbrd",  {27'd0, bus.wb_rd}, 32'd9);
    check("rel_wbd",   bus.wb_data, 32'h0000_000F);
    check("rel_aluop", {26'd0, bus.alu_op}, 32'd2);
    check("rel_rdy",   {31'd0, bus.in_ready}, 32'd1);
    step();
    sample();
    check("rel2_wbrd", {27'd0, bus.wb_rd}, 32'd10);
    check("rel2_wbd",  bus.wb_data, 32'h0000_0100);
    step();
    sample();
    check("rel_done", {31'd0, bus.wb_valid}, 32'd0);

    // srl to r0 executes but never writes
    bus.sb_rd = 5'd0;
    drive(6'd2, 32'h0000_FFFF, 32'd0, 5'd0);
    step();
    idle();
    sample();
    check("r0_alu_op", {26'd0, bus.alu_op}, 32'd2);
    check("r0_sb",     {31'd0, bus.sb_hit}, 32'd0);
    step();
    sample();
    check("r0_no_wb", {31'd0, bus.wb_valid}, 32'd0);

    // unsupported op 9
    drive(6'd9, 32'd1, 32'd1, 5'd11);
    sample();
    check("bad_rdy", {31'd0, bus.in_ready}, 32'd1);
    step();
    idle();
    sample();
    check("bad_op",    {31'd0, bus.bad_op}, 32'd1);
    check("bad_aluop", {26'd0, bus.alu_op}, 32'd0);
    step();
    sample();
    check("bad_no_wb", {31'd0, bus.wb_valid}, 32'd0);
    check("bad_stick", {31'd0, bus.bad_op}, 32'd1);

    // reset with srl r12 sitting in E1
    drive(6'd2, 32'd8, 32'd1, 5'd12);
    step();
    idle();
    rst = 1'b1;
    sample();
    check("rstmid_aluop", {26'd0, bus.alu_op}, 32'd0);
    step();
    rst = 1'b0;
    sample();
    check("rstmid_wbv",  {31'd0, bus.wb_valid}, 32'd0);
    check("rstmid_bad",  {31'd0, bus.bad_op}, 32'd0);
    check("rstmid_rdy",  {31'd0, bus.in_ready}, 32'd1);
    check("rstmid_alu2", {26'd0, bus.alu_op}, 32'd0);
    step();
    sample();
    check("rstmid_wbv2", {31'd0, bus.wb_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
